// File: rtl/vga_frame_scanner.sv
// VGA scanner: pix_tick-gated H/V counters, two-stage pipeline to the pins, scaled framebuffer readout.
// Optional colour-bar generator (adds the test_mode port) is enabled by defining VGA_TEST_PATTERN_EN.
module vga_frame_scanner #(
    parameter int ColorBits   = 3,
    parameter int ImageWidth  = 320,
    parameter int ImageHeight = 240,
    parameter int Scale       = 2,
    parameter int HActive     = 640,
    parameter int HFront      = 16,
    parameter int HSync       = 96,
    parameter int HBack       = 48,
    parameter int VActive     = 480,
    parameter int VFront      = 10,
    parameter int VSync       = 2,
    parameter int VBack       = 33,
    parameter logic [ColorBits-1:0] BgColor = '0
) (
    input  logic                            clk,
    input  logic                            reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                            test_mode,
`endif
    input  logic [ColorBits-1:0]            readValueMemory,
    output logic [$clog2(ImageWidth)-1:0]   XRead,
    output logic [$clog2(ImageHeight)-1:0]  YRead,
    output logic                            hsync,
    output logic                            vsync,
    output logic [7:0]                      red,
    output logic [7:0]                      green,
    output logic [7:0]                      blue,
    output logic                            blank,
    output logic                            clkVGA,
    output logic                            frame_start
);
    localparam int HTotal = HActive + HFront + HSync + HBack;
    localparam int VTotal = VActive + VFront + VSync + VBack;
    localparam int HW  = $clog2(HTotal);
    localparam int VW  = $clog2(VTotal);
    localparam int XW  = $clog2(ImageWidth);
    localparam int YW  = $clog2(ImageHeight);
    localparam int HQW = (XW > HW) ? XW : HW;
    localparam int VQW = (YW > VW) ? YW : VW;
    localparam int SW  = (Scale > 1) ? $clog2(Scale) : 1;
    localparam int CW  = ColorBits / 3;

    localparam logic [31:0] H_ACT = HActive;
    localparam logic [31:0] V_ACT = VActive;
    localparam logic [31:0] H_SS  = HActive + HFront;
    localparam logic [31:0] H_SE  = HActive + HFront + HSync;
    localparam logic [31:0] V_SS  = VActive + VFront;
    localparam logic [31:0] V_SE  = VActive + VFront + VSync;
    localparam logic [31:0] H_IMG = ImageWidth * Scale;
    localparam logic [31:0] V_IMG = ImageHeight * Scale;
    localparam logic [HW-1:0] H_LAST = HW'(HTotal - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VTotal - 1);
    localparam logic [SW-1:0] S_LAST = SW'(Scale - 1);

    // Replicate an N-bit channel MSB-first across 8 DAC bits.
    function automatic logic [7:0] expand(input logic [CW-1:0] ch);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[7-i] = ch[CW-1-(i%CW)];
        end
        return res;
    endfunction

    logic            r_pix_tick;
    logic [HW-1:0]   r_h_cnt;
    logic [VW-1:0]   r_v_cnt;
    logic [SW-1:0]   r_h_sub;
    logic [SW-1:0]   r_v_sub;
    logic [HQW-1:0]  r_h_quo;
    logic [VQW-1:0]  r_v_quo;
    logic            r_frame_start;

    logic            w_h_end;
    logic            w_v_end;
    assign w_h_end = (r_h_cnt == H_LAST);
    assign w_v_end = (r_v_cnt == V_LAST);

    // Counters and the divide-by-Scale quotients move together so XRead/YRead need no divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_tick    <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_h_sub       <= '0;
            r_v_sub       <= '0;
            r_h_quo       <= '0;
            r_v_quo       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_tick    <= ~r_pix_tick;
            r_frame_start <= r_pix_tick && w_h_end && w_v_end;
            if (r_pix_tick) begin
                if (w_h_end) begin
                    r_h_cnt <= '0;
                    r_h_sub <= '0;
                    r_h_quo <= '0;
                    if (w_v_end) begin
                        r_v_cnt <= '0;
                        r_v_sub <= '0;
                        r_v_quo <= '0;
                    end else begin
                        r_v_cnt <= r_v_cnt + 1'b1;
                        if (r_v_sub == S_LAST) begin
                            r_v_sub <= '0;
                            r_v_quo <= r_v_quo + 1'b1;
                        end else begin
                            r_v_sub <= r_v_sub + 1'b1;
                        end
                    end
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                    if (r_h_sub == S_LAST) begin
                        r_h_sub <= '0;
                        r_h_quo <= r_h_quo + 1'b1;
                    end else begin
                        r_h_sub <= r_h_sub + 1'b1;
                    end
                end
            end
        end
    end

    // Stage 0: decode from the counters.
    logic [31:0] w_h32;
    logic [31:0] w_v32;
    logic        w_active;
    logic        w_in_img;
    logic        w_hsync_n;
    logic        w_vsync_n;
    logic        w_addr_en;
    assign w_h32     = 32'(r_h_cnt);
    assign w_v32     = 32'(r_v_cnt);
    assign w_active  = (w_h32 < H_ACT) && (w_v32 < V_ACT);
    assign w_in_img  = (w_h32 < H_IMG) && (w_v32 < V_IMG);
    assign w_hsync_n = !((w_h32 >= H_SS) && (w_h32 < H_SE));
    assign w_vsync_n = !((w_v32 >= V_SS) && (w_v32 < V_SE));
    // Clipping: an image wider/taller than the active area is never addressed past it.
    assign w_addr_en = w_active && w_in_img;

    // Stage 1
    logic          r_s1_active;
    logic          r_s1_in_img;
    logic          r_s1_hsync;
    logic          r_s1_vsync;
    logic [XW-1:0] r_x_read;
    logic [YW-1:0] r_y_read;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0]    w_bar;
    logic [2:0]    r_s1_bar;
    assign w_bar = 3'((w_h32 * 32'd8) / H_ACT);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_active <= 1'b0;
            r_s1_in_img <= 1'b0;
            r_s1_hsync  <= 1'b1;
            r_s1_vsync  <= 1'b1;
            r_x_read    <= '0;
            r_y_read    <= '0;
`ifdef VGA_TEST_PATTERN_EN
            r_s1_bar    <= '0;
`endif
        end else if (r_pix_tick) begin
            r_s1_active <= w_active;
            r_s1_in_img <= w_in_img;
            r_s1_hsync  <= w_hsync_n;
            r_s1_vsync  <= w_vsync_n;
            r_x_read    <= w_addr_en ? r_h_quo[XW-1:0] : '0;
            r_y_read    <= w_addr_en ? r_v_quo[YW-1:0] : '0;
`ifdef VGA_TEST_PATTERN_EN
            r_s1_bar    <= w_bar;
`endif
        end
    end

    logic [7:0] w_mem_ch [3];
    logic [7:0] w_bg_ch  [3];
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            assign w_mem_ch[gi] = expand(readValueMemory[ColorBits-1-gi*CW -: CW]);
            assign w_bg_ch[gi]  = expand(BgColor[ColorBits-1-gi*CW -: CW]);
        end
    endgenerate

    // Stage 2: memory data arrives one clk after the stage-1 address, well before this tick.
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic [7:0] r_red;
    logic [7:0] r_green;
    logic [7:0] r_blue;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_blank <= 1'b0;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (r_pix_tick) begin
            r_hsync <= r_s1_hsync;
            r_vsync <= r_s1_vsync;
            r_blank <= r_s1_active;
            if (!r_s1_active) begin
                r_red   <= '0;
                r_green <= '0;
                r_blue  <= '0;
`ifdef VGA_TEST_PATTERN_EN
            end else if (test_mode) begin
                r_red   <= {8{r_s1_bar[2]}};
                r_green <= {8{r_s1_bar[1]}};
                r_blue  <= {8{r_s1_bar[0]}};
`endif
            end else if (r_s1_in_img) begin
                r_red   <= w_mem_ch[0];
                r_green <= w_mem_ch[1];
                r_blue  <= w_mem_ch[2];
            end else begin
                r_red   <= w_bg_ch[0];
                r_green <= w_bg_ch[1];
                r_blue  <= w_bg_ch[2];
            end
        end
    end

    assign XRead       = r_x_read;
    assign YRead       = r_y_read;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign blank       = r_blank;
    assign clkVGA      = r_pix_tick;
    assign frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_frame_scanner.sv
// Scoreboard bench for vga_frame_scanner on a shrunken timing set: 6-bit colour, 4x2 image at Scale 3.
module tb_vga_frame_scanner;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int SC = 3;
    localparam int IW = 4, IH = 2;
    localparam logic [5:0] BG = 6'b00_11_00;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] readValueMemory = '0;
    logic [1:0] XRead;
    logic [0:0] YRead;
    logic       hsync, vsync, blank, clkVGA, frame_start;
    logic [7:0] red, green, blue;
`ifdef VGA_TEST_PATTERN_EN
    logic       test_mode = 1'b0;
`endif

    vga_frame_scanner #(
        .ColorBits(6), .ImageWidth(IW), .ImageHeight(IH), .Scale(SC),
        .HActive(HA), .HFront(HF), .HSync(HS), .HBack(HB),
        .VActive(VA), .VFront(VF), .VSync(VS), .VBack(VB),
        .BgColor(BG)
    ) dut (
        .clk(clk), .reset(reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode(test_mode),
`endif
        .readValueMemory(readValueMemory),
        .XRead(XRead), .YRead(YRead),
        .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue),
        .blank(blank), .clkVGA(clkVGA), .frame_start(frame_start)
    );

    always #10 clk = ~clk;

    function automatic logic [5:0] mem_code(input int x, input int y);
        return 6'((x * 11 + y * 37 + 6) & 63);
    endfunction

    // Framebuffer model: data one clk after the address.
    always @(posedge clk) readValueMemory <= mem_code(int'(XRead), int'(YRead));

    typedef struct {
        logic       hs, vs, bl;
        logic [7:0] r, g, b;
        logic [1:0] xr;
        logic [0:0] yr;
    } exp_t;

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        logic act, img;
        logic [5:0] c;
        act  = (h < HA) && (v < VA);
        img  = (h < IW * SC) && (v < IH * SC);
        e.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        e.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        e.bl = act;
        e.xr = (act && img) ? 2'(h / SC) : 2'd0;
        e.yr = (act && img) ? 1'(v / SC) : 1'd0;
        c    = img ? mem_code(h / SC, v / SC) : BG;
        e.r  = act ? {4{c[5:4]}} : 8'h00;
        e.g  = act ? {4{c[3:2]}} : 8'h00;
        e.b  = act ? {4{c[1:0]}} : 8'h00;
        return e;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    exp_t q[$];
    exp_t e;
    exp_t ex;
    int   mh, mv;
    logic m_tick, exp_fs, rst_s, tick_edge;

    initial begin
        mh = 0; mv = 0; m_tick = 1'b0; exp_fs = 1'b0;
        for (int cyc = 0; cyc < 3200; cyc++) begin
            @(posedge clk);
            rst_s     = reset;
            tick_edge = 1'b0;
            if (rst_s) begin
                m_tick = 1'b0; mh = 0; mv = 0; exp_fs = 1'b0;
                q.delete();
            end else begin
                exp_fs = m_tick && (mh == HT - 1) && (mv == VT - 1);
                if (m_tick) begin
                    tick_edge = 1'b1;
                    if (mh == HT - 1) begin
                        mh = 0;
                        mv = (mv == VT - 1) ? 0 : mv + 1;
                    end else begin
                        mh = mh + 1;
                    end
                end
                m_tick = ~m_tick;
            end
            #1;
            chk("clkVGA", 32'(clkVGA), 32'(m_tick));
            chk("frame_start", 32'(frame_start), 32'(exp_fs));
            if (frame_start) $display("frame_start at cycle %0d", cyc);
            if (rst_s) begin
                chk("rst_hsync", 32'(hsync), 32'd1);
                chk("rst_vsync", 32'(vsync), 32'd1);
                chk("rst_blank", 32'(blank), 32'd0);
                chk("rst_rgb", {8'h0, red, green, blue}, 32'd0);
                chk("rst_xy", {29'd0, XRead, YRead}, 32'd0);
            end else if (tick_edge) begin
                q.push_back(model(mh, mv));
                if (q.size() >= 2) begin
                    ex = q[q.size() - 2];
                    chk("XRead", 32'(XRead), 32'(ex.xr));
                    chk("YRead", 32'(YRead), 32'(ex.yr));
                end
                if (q.size() >= 3) begin
                    e = q.pop_front();
                    chk("hsync", 32'(hsync), 32'(e.hs));
                    chk("vsync", 32'(vsync), 32'(e.vs));
                    chk("blank", 32'(blank), 32'(e.bl));
                    chk("red",   32'(red),   32'(e.r));
                    chk("green", 32'(green), 32'(e.g));
                    chk("blue",  32'(blue),  32'(e.b));
                end
            end
            // Power-on reset, then a 3-clk reset in the middle of the second frame.
            reset = (cyc < 4) || (cyc >= 1100 && cyc < 1103);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
